// File: rtl/up5bit_count_checker.sv
// Lock-and-compare checker for a free-running modulo-2^WIDTH up-counter stream.
// Optional wrap statistics are built only when UP5_CHK_WRAP_CNT_EN is defined.
module up5bit_count_checker #(
    parameter int WIDTH     = 5,
    parameter int ERR_CNT_W = 8,
    parameter int LOCK_LEN  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 count_valid,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [7:0]           wrap_count,
    output logic [WIDTH-1:0]     expected
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_LEN);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev, prev_nxt, prev_inc;
    logic [3:0]       run, run_nxt;
    logic             good, stall, bad, err_nxt;

    assign prev_inc = prev + 1'b1;
    assign good     = count_valid && (count_in == prev_inc);
    assign stall    = count_valid && (count_in == prev);
    assign bad      = count_valid && !good && !stall;

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        run_nxt   = run;
        err_nxt   = 1'b0;
        if (count_valid)
            prev_nxt = count_in;
        case (state)
            IDLE: begin
                if (count_valid) begin
                    run_nxt   = 4'd0;
                    state_nxt = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (good) begin
                    run_nxt = run + 4'd1;
                    if (run_nxt == LOCK_RUN)
                        state_nxt = LOCKED;
                end else if (bad) begin
                    run_nxt = 4'd0;
                end
            end
            LOCKED: begin
                // A mismatch while locked is reported, then we re-acquire from it.
                if (bad) begin
                    err_nxt   = 1'b1;
                    run_nxt   = 4'd0;
                    state_nxt = ACQUIRE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prev      <= '0;
            run       <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            expected  <= WIDTH'(1);
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            run       <= run_nxt;
            locked    <= (state_nxt == LOCKED);
            err_pulse <= err_nxt;
            expected  <= prev_nxt + 1'b1;
        end
    end

    // clear has priority over a same-cycle increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_count <= '0;
        else if (clear)
            err_count <= '0;
        else if (err_nxt && (err_count != '1))
            err_count <= err_count + 1'b1;
    end

`ifdef UP5_CHK_WRAP_CNT_EN
    logic wrap_step;
    assign wrap_step = good && (prev == '1) && (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wrap_count <= 8'd0;
        else if (clear)
            wrap_count <= 8'd0;
        else if (wrap_step && (wrap_count != 8'hff))
            wrap_count <= wrap_count + 8'd1;
    end
`else
    assign wrap_count = 8'd0;
`endif

endmodule

// File: tb/tb_up5bit_count_checker.sv
// Randomized and directed bench for up5bit_count_checker against a streak-based reference model.
module tb_up5bit_count_checker;

    localparam int LL = 4;

    logic       clk = 1'b0;
    logic       reset, count_valid, clear;
    logic [4:0] count_in;
    logic       locked, err_pulse;
    logic [7:0] err_count, wrap_count;
    logic [4:0] expected;

    int checks = 0;
    int errors = 0;

    int m_prev, m_streak, m_err, m_wrap;
    bit m_have, m_pulse;

`ifdef UP5_CHK_WRAP_CNT_EN
    localparam bit WRAP_ON = 1'b1;
`else
    localparam bit WRAP_ON = 1'b0;
`endif

    up5bit_count_checker dut (
        .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid),
        .clear(clear), .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .wrap_count(wrap_count), .expected(expected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic bit m_locked();
        return m_have && (m_streak >= LL);
    endfunction

    task automatic model_reset();
        m_prev = 0; m_have = 0; m_streak = 0; m_err = 0; m_wrap = 0; m_pulse = 0;
    endtask

    // Lock = at least LL good steps since the last resync point.
    task automatic model_step(input bit v, input int d, input bit c);
        bit lk;
        lk = m_locked();
        m_pulse = 0;
        if (v) begin
            if (!m_have) begin
                m_have = 1; m_streak = 0; m_prev = d;
            end else if (d == m_prev) begin
            end else if (d == (m_prev + 1) % 32) begin
                if (m_prev == 31 && m_wrap < 255) m_wrap++;
                m_streak++;
                m_prev = d;
            end else begin
                if (lk) begin
                    m_pulse = 1;
                    if (m_err < 255) m_err++;
                end
                m_streak = 0;
                m_prev = d;
            end
        end
        if (c) begin
            m_err = 0;
            m_wrap = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked"}, locked, m_locked());
        chk({tag, ".pulse"}, err_pulse, m_pulse);
        chk({tag, ".err"}, err_count, m_err);
        chk({tag, ".wrap"}, wrap_count, WRAP_ON ? m_wrap : 0);
        chk({tag, ".exp"}, expected, (m_prev + 1) % 32);
    endtask

    task automatic cyc(input bit v, input int d, input bit c, input string tag);
        count_valid = v;
        count_in    = 5'(d);
        clear       = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        check_all(tag);
        count_valid = 1'b0;
        clear       = 1'b0;
    endtask

    initial begin
        int r, d;
        reset = 1'b1; count_valid = 1'b0; clear = 1'b0; count_in = '0;
        model_reset();
        #2;
        check_all("reset");
        chk("reset_exp1", expected, 1);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i <= 4; i++) cyc(1, i, 0, "acq");
        chk("lock_after_4", locked, 1);
        chk("lock_exp5", expected, 5);

        for (int i = 5; i <= 7; i++) cyc(1, i, 0, "run");
        cyc(1, 9, 0, "bad9");
        chk("bad9_pulse", err_pulse, 1);
        chk("bad9_err", err_count, 1);
        chk("bad9_unlock", locked, 0);
        chk("bad9_exp", expected, 10);
        for (int i = 10; i <= 13; i++) cyc(1, i, 0, "relock");
        chk("relock", locked, 1);

        for (int i = 14; i <= 31; i++) cyc(1, i, 0, "towrap");
        cyc(1, 0, 0, "wrap0");
        cyc(1, 1, 0, "wrap1");
        chk("wrap_cnt", wrap_count, WRAP_ON ? 1 : 0);
        chk("wrap_noerr", err_count, 1);

        for (int i = 2; i <= 5; i++) cyc(1, i, 0, "pre_stall");
        cyc(0, 0, 0, "gap"); cyc(1, 5, 0, "stall");
        cyc(0, 0, 0, "gap"); cyc(1, 5, 0, "stall");
        cyc(0, 0, 0, "gap"); cyc(1, 6, 0, "stall6");
        chk("stall_locked", locked, 1);
        chk("stall_exp", expected, 7);
        chk("stall_err", err_count, 1);

        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      cyc(1, (m_prev + 1) % 32, ($urandom_range(0, 99) < 3), "rnd_good");
            else if (r < 78) cyc(1, m_prev, 0, "rnd_stall");
            else if (r < 88) cyc(0, $urandom_range(0, 31), ($urandom_range(0, 99) < 5), "rnd_idle");
            else begin
                do d = $urandom_range(0, 31);
                while (d == m_prev || d == (m_prev + 1) % 32);
                cyc(1, d, ($urandom_range(0, 99) < 10), "rnd_bad");
            end
        end

        for (int n = 0; n < 300; n++) begin
            cyc(1, (m_prev + 5) % 32, 0, "sat_bad");
            for (int k = 0; k < LL; k++) cyc(1, (m_prev + 1) % 32, 0, "sat_good");
        end
        chk("err_sat", err_count, 255);
        chk("sat_locked", locked, 1);
        cyc(1, (m_prev + 5) % 32, 1, "clr_bad");
        chk("clr_err0", err_count, 0);
        chk("clr_pulse", err_pulse, 1);
        chk("clr_wrap0", wrap_count, 0);

        for (int k = 0; k < 6; k++) cyc(1, (m_prev + 1) % 32, 0, "pre_arst");
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        chk("arst_locked", locked, 0);
        chk("arst_exp", expected, 1);
        #2 reset = 1'b0;
        cyc(1, 20, 0, "post20");
        chk("post20_locked", locked, 0);
        chk("post20_pulse", err_pulse, 0);
        chk("post20_exp", expected, 21);
        for (int i = 21; i <= 24; i++) cyc(1, i, 0, "post_lock");
        chk("post_lock", locked, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
